// File: rtl/cp0_int_ctrl.sv
// Coprocessor-0: SR/Cause/EPC/PRId storage, mtc0/mfc0 access, interrupt request
// generation from HWInt[7:2], and exception entry / eret bookkeeping.
module cp0_int_ctrl #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4D50,
    parameter logic [4:0]  EXC_INT    = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    output logic [31:0] dout,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] din,
    input  logic [5:0]  hw_int,
    input  logic [29:0] pc,
    input  logic        bd,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        exl_set,
    input  logic        exl_clr,
    output logic        int_req,
    output logic [29:0] epc
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic [5:0]  ip_q, ip_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [29:0] epc_q, epc_d;

    logic [31:0] sr_rd;
    logic [31:0] cause_rd;
    logic        wr_sr;
    logic        wr_epc;

    assign int_req = ie_q & ~exl_q & (|(ip_q & im_q));
    assign epc     = epc_q;

    assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_rd = {bd_q, 15'b0, ip_q, 3'b0, code_q, 2'b00};

    always_comb begin
        dout = 32'b0;
        case (rd_addr)
            REG_SR:    dout = sr_rd;
            REG_CAUSE: dout = cause_rd;
            REG_EPC:   dout = {epc_q, 2'b00};
            REG_PRID:  dout = PRID_VALUE;
            default:   dout = 32'b0;
        endcase
    end

    assign wr_sr  = we && (wr_addr == REG_SR);
    assign wr_epc = we && (wr_addr == REG_EPC);

    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        ip_d   = hw_int;
        bd_d   = bd_q;
        code_d = code_q;
        epc_d  = epc_q;

        if (wr_sr) begin
            im_d  = din[15:10];
            exl_d = din[1];
            ie_d  = din[0];
        end
        if (wr_epc) begin
            epc_d = din[31:2];
        end

        // Entry overrides both the mtc0 EXL/EPC value and a concurrent eret.
        if (exl_set) begin
            exl_d = 1'b1;
            epc_d = pc;
            bd_d  = bd;
            if (int_req || !exc_req) begin
                code_d = EXC_INT;
            end else begin
                code_d = exc_code;
            end
        end else if (exl_clr) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q   <= 6'b0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            ip_q   <= 6'b0;
            bd_q   <= 1'b0;
            code_q <= 5'b0;
            epc_q  <= 30'b0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            ip_q   <= ip_d;
            bd_q   <= bd_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

endmodule
